// File: rtl/keccak_pkg.sv
// Shared Keccak types and helpers: 5x5 state of 64-bit lanes addressed as state[y][x],
// plus the linear lane index i = x + 5y used by the output and absorb ends.
package keccak_pkg;

  localparam int N      = 64;
  localparam int LANE_W = 64;

  typedef logic [4:0][LANE_W-1:0]      plane;
  typedef logic [4:0][4:0][LANE_W-1:0] state;
  typedef logic [4:0]                  lane_idx_t;

  function automatic logic [LANE_W-1:0] lane_of(state s, lane_idx_t i);
    lane_idx_t y;
    lane_idx_t x;
    y = lane_idx_t'(i / 5'd5);
    x = lane_idx_t'(i % 5'd5);
    return s[y[2:0]][x[2:0]];
  endfunction

endpackage

// File: rtl/keccak_squeeze_if.sv
// Digest output stream: 64-bit lanes with byte keep, valid/ready handshake and last marker.
interface keccak_squeeze_if;

  logic [63:0] out_data;
  logic [7:0]  out_keep;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  modport master (output out_data, output out_keep, output out_valid, output out_last,
                  input  out_ready);
  modport slave  (input  out_data, input  out_keep, input  out_valid, input  out_last,
                  output out_ready);

endinterface

// File: rtl/keccak_lane_mux.sv
// Combinational 25:1 lane select from a Keccak state by linear lane index (i = x + 5y).
module keccak_lane_mux
  import keccak_pkg::*;
(
  input  state                    a,
  input  lane_idx_t               sel,
  output logic [LANE_W-1:0]       lane
);

  assign lane = lane_of(a, sel);

endmodule

// File: rtl/keccak_squeeze.sv
// Captures a finished Keccak state and streams the first OUT_BITS of it as 64-bit lanes.
// Build option KECCAK_SQUEEZE_BSWAP_EN presents each word byte-reversed (big-endian hex order).
module keccak_squeeze
  import keccak_pkg::*;
#(
  parameter int OUT_BITS = 256
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  state                    A_in,
  input  logic                    state_valid,
  output logic                    state_ready,
  keccak_squeeze_if.master        stream
);

  localparam int NUM_WORDS = (OUT_BITS + 63) / 64;
  localparam logic [7:0] KEEP_LAST = (OUT_BITS % 64 == 32) ? 8'h0F : 8'hFF;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]                          fsm;
  lane_idx_t                           idx;
  logic [NUM_WORDS-1:0][LANE_W-1:0]    buffer;
  logic [NUM_WORDS-1:0][LANE_W-1:0]    captured;
  logic [LANE_W-1:0]                   lane_sel;
  logic [LANE_W-1:0]                   masked;
  logic [LANE_W-1:0]                   byte_mask;
  logic [7:0]                          keep;
  logic                                last;
  logic                                sending;

  for (genvar g = 0; g < NUM_WORDS; g++) begin : g_capture
    keccak_lane_mux u_mux (
      .a    (A_in),
      .sel  (lane_idx_t'(g)),
      .lane (captured[g])
    );
  end

  assign sending     = (fsm == SEND);
  assign last        = (idx == lane_idx_t'(NUM_WORDS - 1));
  assign state_ready = !sending;

  // Everything the sink sees is decoded from fsm/idx/buffer, so out_ready never reaches an output.
  always_comb begin
    lane_sel = '0;
    for (int i = 0; i < NUM_WORDS; i++) begin
      if (idx == lane_idx_t'(i)) lane_sel = buffer[i];
    end
  end

  always_comb begin
    keep = sending ? (last ? KEEP_LAST : 8'hFF) : 8'h00;
    byte_mask = '0;
    for (int k = 0; k < 8; k++) byte_mask[8*k +: 8] = {8{keep[k]}};
    masked = lane_sel & byte_mask;
  end

`ifdef KECCAK_SQUEEZE_BSWAP_EN
  always_comb begin
    stream.out_data = '0;
    stream.out_keep = '0;
    for (int k = 0; k < 8; k++) begin
      stream.out_data[8*(7-k) +: 8] = masked[8*k +: 8];
      stream.out_keep[7-k]          = keep[k];
    end
  end
`else
  assign stream.out_data = masked;
  assign stream.out_keep = keep;
`endif

  assign stream.out_valid = sending;
  assign stream.out_last  = sending && last;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm    <= IDLE;
      idx    <= '0;
      buffer <= '0;
    end else begin
      case (fsm)
        IDLE: begin
          if (state_valid) begin
            buffer <= captured;
            idx    <= '0;
            fsm    <= SEND;
          end
        end
        SEND: begin
          if (stream.out_ready) begin
            if (last) fsm <= IDLE;
            else      idx <= idx + 5'd1;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule
